// File: rtl/data_memory_controller.sv
// Word-organised data memory behind a request/ready handshake with programmable wait states,
// per-byte write lanes and an out-of-range error flag reported alongside the completion pulse.
module data_memory_controller #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [3:0]  byte_select,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    // Handshake: a request is taken only in IDLE (busy=0); ready pulses for one
    // cycle on completion and error is meaningful only while ready=1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t      state;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [29:0] lat_addr;
    logic [3:0]  lat_sel;
    logic [31:0] lat_data;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        commit;
    logic        eff_we;
    logic [29:0] eff_addr;
    logic [3:0]  eff_sel;
    logic [31:0] eff_data;
    logic        in_range;
    logic [ADDR_WIDTH-1:0] word_idx;

    // Byte offset bits never select anything in a word-organised array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[1:0];

    assign accept = (state == IDLE) && request;

    // With no wait states the access commits on the accept edge itself, so the
    // live inputs are used instead of the (not yet loaded) latches.
    assign commit   = NO_WAIT ? accept : ((state == WAIT) && (wait_cnt == 4'd1));
    assign eff_we   = NO_WAIT ? write_enable  : lat_we;
    assign eff_addr = NO_WAIT ? address[31:2] : lat_addr;
    assign eff_sel  = NO_WAIT ? byte_select   : lat_sel;
    assign eff_data = NO_WAIT ? data_in       : lat_data;

    assign in_range = ((eff_addr >> ADDR_WIDTH) == 30'd0);
    assign word_idx = eff_addr[ADDR_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lat_we   <= 1'b0;
            lat_addr <= 30'd0;
            lat_sel  <= 4'd0;
            lat_data <= 32'd0;
            data_out <= 32'd0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        lat_we   <= write_enable;
                        lat_addr <= address[31:2];
                        lat_sel  <= byte_select;
                        lat_data <= data_in;
                        wait_cnt <= WAIT_LOAD;
                        busy     <= 1'b1;
                        state    <= NO_WAIT ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (commit) begin
                ready <= 1'b1;
                error <= ~in_range;
                if (!eff_we) begin
                    data_out <= in_range ? mem[word_idx] : 32'd0;
                end
            end
        end
    end

    // Kept out of the reset block so the array contents survive reset, while a
    // reset landing on the commit edge still blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && commit && eff_we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_sel[i]) begin
                    mem[word_idx][8*i +: 8] <= eff_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share the data inputs; a word-level memory model feeds per-instance expected queues.
module tb_data_memory_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic        write_enable;
    logic [31:0] address;
    logic [3:0]  byte_select;
    logic [31:0] data_in;
    logic [31:0] data_out_a, data_out_b;
    logic        ready_a, busy_a, error_a;
    logic        ready_b, busy_b, error_b;

    always #5 clock = ~clock;

    data_memory_controller #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .request(req_a), .write_enable(write_enable),
        .address(address), .byte_select(byte_select), .data_in(data_in),
        .data_out(data_out_a), .ready(ready_a), .busy(busy_a), .error(error_a)
    );

    data_memory_controller #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .request(req_b), .write_enable(write_enable),
        .address(address), .byte_select(byte_select), .data_in(data_in),
        .data_out(data_out_b), .ready(ready_b), .busy(busy_b), .error(error_b)
    );

    int          tests_run = 0;
    int          failures  = 0;
    logic [32:0] exp_qa[$];
    logic [32:0] exp_qb[$];
    logic [31:0] mem_m[2][1024];
    logic [31:0] last_ld[2];
    time         last_acc[2];
    bit          spacing_on[2];
    int          ready_cnt[2];

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic busy_w(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic ready_w(input int w);
        return (w == 0) ? ready_a : ready_b;
    endfunction

    // Reference model: expected {error, data_out} for one access.
    task automatic model_op(input int w, input logic we, input logic [31:0] addr,
                            input logic [3:0] sel, input logic [31:0] din,
                            output logic [32:0] expv);
        logic       inr;
        logic [9:0] idx;
        inr = (addr[31:12] == 20'd0);
        idx = addr[11:2];
        if (we) begin
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) mem_m[w][idx][8*i +: 8] = din[8*i +: 8];
                end
            end
            expv = {~inr, last_ld[w]};
        end else begin
            expv = inr ? {1'b0, mem_m[w][idx]} : {1'b1, 32'd0};
            last_ld[w] = expv[31:0];
        end
    endtask

    // Scoreboard: every completion pops and compares one expected entry.
    always @(negedge clock) begin
        if (ready_a === 1'b1) begin
            ready_cnt[0]++;
            check("a_pending_on_ready", 33'(exp_qa.size() != 0), 33'd1);
            if (exp_qa.size() != 0) check("a_result", {error_a, data_out_a}, exp_qa.pop_front());
        end
        if (ready_b === 1'b1) begin
            ready_cnt[1]++;
            check("b_pending_on_ready", 33'(exp_qb.size() != 0), 33'd1);
            if (exp_qb.size() != 0) check("b_result", {error_b, data_out_b}, exp_qb.pop_front());
        end
    end

    task automatic wait_idle(input int w);
        int guard;
        guard = 0;
        while (busy_w(w) !== 1'b0 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 40) check("idle_timeout", 33'(guard), 33'd0);
    endtask

    task automatic access(input int w, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] din);
        int          lat;
        int          exp_lat;
        logic [32:0] expv;
        exp_lat = (w == 0) ? 3 : 1;
        @(negedge clock);
        wait_idle(w);
        model_op(w, we, addr, sel, din, expv);
        if (w == 0) exp_qa.push_back(expv);
        else        exp_qb.push_back(expv);
        write_enable = we;
        address      = addr;
        byte_select  = sel;
        data_in      = din;
        if (w == 0) req_a = 1'b1;
        else        req_b = 1'b1;
        @(posedge clock);
        if (spacing_on[w] && last_acc[w] != 0)
            check("accept_spacing", 33'(($time - last_acc[w]) / 10), 33'(exp_lat + 1));
        last_acc[w] = $time;
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (ready_w(w) !== 1'b1 && lat < 20);
        check("ready_latency", 33'(lat), 33'(exp_lat));
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, {busy_a, ready_a, error_a, data_out_a}, 35'd0);
    endtask

    initial begin
        int rc0;
        int busy_n;
        reset        = 1'b1;
        req_a        = 1'b0;
        req_b        = 1'b0;
        write_enable = 1'b0;
        address      = 32'd0;
        byte_select  = 4'd0;
        data_in      = 32'd0;
        last_ld[0]   = 32'd0;
        last_ld[1]   = 32'd0;
        last_acc[0]  = 0;
        last_acc[1]  = 0;
        ready_cnt[0] = 0;
        ready_cnt[1] = 0;

        repeat (3) @(negedge clock);
        check("reset_a", {busy_a, ready_a, error_a, data_out_a}, 35'd0);
        check("reset_b", {busy_b, ready_b, error_b, data_out_b}, 35'd0);
        reset = 1'b0;

        // Full-word store/load, lane store, range error, empty lane mask.
        spacing_on[0] = 1'b1;
        access(0, 1'b1, 32'h0000_0000, 4'b1111, 32'h1122_3344);
        access(0, 1'b1, 32'h0000_0008, 4'b1111, 32'h4455_6677);
        access(0, 1'b0, 32'h0000_0008, 4'b0000, 32'h0);
        access(0, 1'b1, 32'h0000_0008, 4'b0010, 32'h0000_AA00);
        access(0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0);
        access(0, 1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0);
        access(0, 1'b0, 32'h0000_1004, 4'b1111, 32'h0);
        access(0, 1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF);
        access(0, 1'b0, 32'h0000_0009, 4'b0101, 32'h0);
        access(0, 1'b0, 32'h8000_0008, 4'b1111, 32'h0);
        spacing_on[0] = 1'b0;

        // A second request while busy must be dropped.
        @(negedge clock);
        wait_idle(0);
        begin
            logic [32:0] expv;
            model_op(0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, expv);
            exp_qa.push_back(expv);
        end
        rc0 = ready_cnt[0];
        write_enable = 1'b0;
        address      = 32'h0000_0008;
        req_a        = 1'b1;
        @(posedge clock);
        #1 req_a = 1'b0;
        busy_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (busy_a === 1'b1) busy_n++;
            if (k == 1) begin
                write_enable = 1'b1;
                data_in      = 32'h0BAD_0BAD;
                req_a        = 1'b1;
            end
            if (k == 2) req_a = 1'b0;
        end
        check("busy_cycles", 33'(busy_n), 33'd3);
        check("ready_pulses_busy", 33'(ready_cnt[0] - rc0), 33'd1);
        access(0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0);

        // Reset one edge after accept aborts the store.
        access(0, 1'b1, 32'h0000_000C, 4'b1111, 32'h0BAD_C0DE);
        @(negedge clock);
        wait_idle(0);
        rc0          = ready_cnt[0];
        write_enable = 1'b1;
        address      = 32'h0000_000C;
        byte_select  = 4'b1111;
        data_in      = 32'hCAFE_F00D;
        req_a        = 1'b1;
        @(posedge clock);
        #1 req_a = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_ld[0] = 32'd0;
        last_ld[1] = 32'd0;
        check_zero_outputs("reset_at_e1_outputs");
        repeat (4) @(negedge clock);
        check("reset_at_e1_no_ready", 33'(ready_cnt[0] - rc0), 33'd0);
        access(0, 1'b0, 32'h0000_000C, 4'b1111, 32'h0);

        // Reset on the commit edge suppresses the write and the ready pulse.
        @(negedge clock);
        wait_idle(0);
        rc0          = ready_cnt[0];
        write_enable = 1'b1;
        address      = 32'h0000_000C;
        data_in      = 32'hCAFE_F00D;
        req_a        = 1'b1;
        @(posedge clock);
        #1 req_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_ld[0] = 32'd0;
        last_ld[1] = 32'd0;
        check_zero_outputs("reset_at_commit_outputs");
        repeat (4) @(negedge clock);
        check("reset_at_commit_no_ready", 33'(ready_cnt[0] - rc0), 33'd0);
        access(0, 1'b0, 32'h0000_000C, 4'b1111, 32'h0);

        // Zero-wait instance: back-to-back accepts every two cycles, random traffic.
        spacing_on[1] = 1'b1;
        last_acc[1]   = 0;
        for (int i = 0; i < 8; i++) access(1, 1'b1, 32'(i * 4), 4'b1111, $urandom);
        for (int n = 0; n < 16; n++) begin
            logic       we;
            logic [2:0] idx;
            logic [3:0] sel;
            we  = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            sel = 4'($urandom_range(0, 15));
            access(1, we, {27'd0, idx, 2'b00}, sel, $urandom);
        end
        access(1, 1'b0, 32'h0000_2000, 4'b1111, 32'h0);
        access(1, 1'b1, 32'h0001_0000, 4'b1111, 32'h1234_5678);
        access(1, 1'b0, 32'h0000_0000, 4'b1111, 32'h0);

        repeat (4) @(negedge clock);
        check("queue_a_drained", 33'(exp_qa.size()), 33'd0);
        check("queue_b_drained", 33'(exp_qb.size()), 33'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
